// File: rtl/dmem_ctrl_if.sv
// Request/response and data-memory bus for dmem_ctrl.
// slave is the controller's view; master is the core plus memory side.
interface dmem_ctrl_if #(parameter int ADDR_W = 32);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_wen;
  logic [ADDR_W-1:0] i_req_addr;
  logic [31:0]       i_req_wdata;
  logic [1:0]        i_req_size;
  logic              i_req_unsigned;
  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_misaligned;
  logic              o_mem_ren;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_mask;
  logic              i_mem_ready;
  logic              i_mem_valid;
  logic [31:0]       i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
           i_mem_ready, i_mem_valid, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_misaligned,
           o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
  );

  modport master (
    output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
           i_mem_ready, i_mem_valid, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_misaligned,
           o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
  );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I data-memory responder: lane-steered stores, extended loads, one-cycle response.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned requests instead of force-aligning them.
module dmem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  dmem_ctrl_if.slave  bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic              uns;
  } req_t;

  state_t                       state_q, state_d;
  req_t                         req_q;
  logic [31:0]                  rsp_rdata_q;
  logic [ADDR_W-1:0]            addr_al;
  logic [31:0]                  shifted, load_ext;
  logic [NUM_LANES-1:0][7:0]    lane_wdata;
  logic [NUM_LANES-1:0]         lane_mask;
  logic                         trap;
  logic                         enter_resp;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic rsp_misal_q;

  always_comb begin
    case (bus.i_req_size)
      2'b00:   trap = 1'b0;
      2'b01:   trap = bus.i_req_addr[0];
      default: trap = |bus.i_req_addr[1:0];
    endcase
  end

  // Only the trap path enters RESP straight from IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)        rsp_misal_q <= 1'b0;
    else if (enter_resp) rsp_misal_q <= (state_q == IDLE);
  end

  assign bus.o_rsp_misaligned = rsp_misal_q;
`else
  assign trap = 1'b0;
  assign bus.o_rsp_misaligned = 1'b0;
`endif

  // Force-align; a no-op for aligned requests, so shared by both builds.
  always_comb begin
    addr_al = bus.i_req_addr;
    if (bus.i_req_size == 2'b01) addr_al[0]   = 1'b0;
    else if (bus.i_req_size[1])  addr_al[1:0] = 2'b00;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.i_req_valid) state_d = trap ? RESP : REQ;
      REQ:  if (bus.i_mem_ready) state_d = req_q.wen ? RESP : WAIT;
      WAIT: if (bus.i_mem_valid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_q       <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && bus.i_req_valid)
        req_q <= '{wen: bus.i_req_wen, addr: addr_al, wdata: bus.i_req_wdata,
                   size: bus.i_req_size, uns: bus.i_req_unsigned};
      // Stores and traps respond with zero data; rdata holds between responses.
      if (enter_resp)
        rsp_rdata_q <= (state_q == WAIT) ? load_ext : 32'h0;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_wdata[l] = (req_q.size == 2'b00) ? req_q.wdata[7:0] :
                           (req_q.size == 2'b01) ? req_q.wdata[8*(l%2) +: 8] :
                                                   req_q.wdata[8*l +: 8];
    assign lane_mask[l]  = (req_q.size == 2'b00) ? (req_q.addr[1:0] == 2'(l)) :
                           (req_q.size == 2'b01) ? (req_q.addr[1] == 1'(l/2)) :
                                                   1'b1;
  end

  assign shifted = bus.i_mem_rdata >> {req_q.addr[1:0], 3'b000};

  always_comb begin
    case (req_q.size)
      2'b00:   load_ext = {{24{~req_q.uns & shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = {{16{~req_q.uns & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    bus.o_req_ready = 1'b0;
    bus.o_rsp_valid = 1'b0;
    bus.o_mem_ren   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_mask  = 4'b0000;
    case (state_q)
      IDLE: bus.o_req_ready = 1'b1;
      REQ: begin
        bus.o_mem_ren  = ~req_q.wen;
        bus.o_mem_wen  = req_q.wen;
        bus.o_mem_mask = req_q.wen ? lane_mask : 4'b0000;
      end
      RESP: bus.o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_mem_addr  = {req_q.addr[ADDR_W-1:2], 2'b00};
  assign bus.o_mem_wdata = lane_wdata;
  assign bus.o_rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stores, extended loads, stalls, misalignment, reset abort.
module tb_dmem_ctrl;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 i_clk = ~i_clk;

  dmem_ctrl_if #(.ADDR_W(32)) bus();

  dmem_ctrl #(.ADDR_W(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req_valid = 1'b0;  bus.i_req_wen = 1'b0;  bus.i_req_addr = '0;
    bus.i_req_wdata = '0;    bus.i_req_size = 2'b00; bus.i_req_unsigned = 1'b0;
    bus.i_mem_ready = 1'b0;  bus.i_mem_valid = 1'b0; bus.i_mem_rdata = '0;
  endtask

  task automatic present(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
    bus.i_req_valid = 1'b1; bus.i_req_wen = wen; bus.i_req_addr = addr;
    bus.i_req_wdata = wdata; bus.i_req_size = size; bus.i_req_unsigned = uns;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    step(); step();
    total++; if (bus.o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.o_rsp_valid); end
    total++; if (bus.o_rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=0", bus.o_rsp_rdata); end
    total++; if (bus.o_rsp_misaligned !== 1'b0) begin bad++; $display("FAIL rst_misal got=%b exp=0", bus.o_rsp_misaligned); end
    total++; if ({bus.o_mem_ren, bus.o_mem_wen} !== 2'b00) begin bad++; $display("FAIL rst_ren_wen got=%b exp=00", {bus.o_mem_ren, bus.o_mem_wen}); end
    total++; if (bus.o_mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus.o_mem_addr); end
    total++; if (bus.o_mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.o_mem_wdata); end
    total++; if (bus.o_mem_mask !== 4'h0) begin bad++; $display("FAIL rst_mem_mask got=%h exp=0", bus.o_mem_mask); end
    i_rst_n = 1'b1;
    step();
    total++; if (bus.o_req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", bus.o_req_ready); end
  endtask

  task automatic test_store_word();
    present(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0);
    bus.i_mem_ready = 1'b1;
    step();  // T+1
    bus.i_req_valid = 1'b0;
    total++; if ({bus.o_mem_ren, bus.o_mem_wen} !== 2'b01) begin bad++; $display("FAIL sw_ren_wen got=%b exp=01", {bus.o_mem_ren, bus.o_mem_wen}); end
    total++; if (bus.o_mem_addr !== 32'h100) begin bad++; $display("FAIL sw_addr got=%h exp=100", bus.o_mem_addr); end
    total++; if (bus.o_mem_mask !== 4'b1111) begin bad++; $display("FAIL sw_mask got=%b exp=1111", bus.o_mem_mask); end
    total++; if (bus.o_mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", bus.o_mem_wdata); end
    total++; if (bus.o_rsp_valid !== 1'b0) begin bad++; $display("FAIL sw_rsp_early got=%b exp=0", bus.o_rsp_valid); end
    step();  // T+2
    total++; if (bus.o_rsp_valid !== 1'b1) begin bad++; $display("FAIL sw_rsp_valid got=%b exp=1", bus.o_rsp_valid); end
    total++; if (bus.o_rsp_rdata !== 32'h0) begin bad++; $display("FAIL sw_rsp_rdata got=%h exp=0", bus.o_rsp_rdata); end
    total++; if (bus.o_mem_wen !== 1'b0) begin bad++; $display("FAIL sw_wen_drop got=%b exp=0", bus.o_mem_wen); end
    step();  // T+3
    total++; if ({bus.o_rsp_valid, bus.o_req_ready} !== 2'b01) begin bad++; $display("FAIL sw_back_idle got=%b exp=01", {bus.o_rsp_valid, bus.o_req_ready}); end
    idle_inputs();
  endtask

  task automatic test_store_byte();
    present(1'b1, 32'h103, 32'h000000A5, 2'b00, 1'b0);
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_req_valid = 1'b0;
    total++; if (bus.o_mem_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", bus.o_mem_wdata); end
    total++; if (bus.o_mem_mask !== 4'b1000) begin bad++; $display("FAIL sb_mask got=%b exp=1000", bus.o_mem_mask); end
    step();
    total++; if (bus.o_rsp_valid !== 1'b1) begin bad++; $display("FAIL sb_rsp_valid got=%b exp=1", bus.o_rsp_valid); end
    step();
    idle_inputs();
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] exp);
    present(1'b0, 32'h202, 32'h0, 2'b00, uns);
    bus.i_mem_ready = 1'b1;
    step();  // T+1
    bus.i_req_valid = 1'b0;
    total++; if ({bus.o_mem_ren, bus.o_mem_wen} !== 2'b10) begin bad++; $display("FAIL lb_ren_wen got=%b exp=10", {bus.o_mem_ren, bus.o_mem_wen}); end
    total++; if (bus.o_mem_addr !== 32'h200) begin bad++; $display("FAIL lb_addr got=%h exp=200", bus.o_mem_addr); end
    total++; if (bus.o_mem_mask !== 4'b0000) begin bad++; $display("FAIL lb_mask got=%b exp=0000", bus.o_mem_mask); end
    step();  // T+2
    bus.i_mem_ready = 1'b0;
    total++; if (bus.o_mem_ren !== 1'b0) begin bad++; $display("FAIL lb_ren_drop got=%b exp=0", bus.o_mem_ren); end
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h12803456;
    step();  // T+3
    bus.i_mem_valid = 1'b0;
    total++; if (bus.o_rsp_valid !== 1'b1) begin bad++; $display("FAIL lb_rsp_valid uns=%b got=%b exp=1", uns, bus.o_rsp_valid); end
    total++; if (bus.o_rsp_rdata !== exp) begin bad++; $display("FAIL lb_rdata uns=%b got=%h exp=%h", uns, bus.o_rsp_rdata, exp); end
    step();
    total++; if (bus.o_rsp_rdata !== exp) begin bad++; $display("FAIL lb_rdata_hold got=%h exp=%h", bus.o_rsp_rdata, exp); end
    idle_inputs();
  endtask

  task automatic test_load_half_stall();
    present(1'b0, 32'h302, 32'h0, 2'b01, 1'b0);
    step();  // T+1: ready low; stray valid during REQ must be ignored
    bus.i_req_valid = 1'b0;
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h5555AAAA;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) bus.i_mem_ready = 1'b1;
      total++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_addr !== 32'h300 || bus.o_mem_mask !== 4'h0) begin
        bad++; $display("FAIL lh_stall c=%0d ren=%b addr=%h mask=%b exp 1/300/0", c, bus.o_mem_ren, bus.o_mem_addr, bus.o_mem_mask);
      end
      step();
      if (c == 1) bus.i_mem_valid = 1'b0;
    end
    // T+4: WAIT, valid still low
    bus.i_mem_ready = 1'b0;
    total++; if (bus.o_rsp_valid !== 1'b0) begin bad++; $display("FAIL lh_rsp_t4 got=%b exp=0", bus.o_rsp_valid); end
    step();  // T+5
    total++; if (bus.o_rsp_valid !== 1'b0) begin bad++; $display("FAIL lh_rsp_t5 got=%b exp=0", bus.o_rsp_valid); end
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h80010000;
    step();  // T+6
    bus.i_mem_valid = 1'b0;
    total++; if (bus.o_rsp_valid !== 1'b1) begin bad++; $display("FAIL lh_rsp_t6 got=%b exp=1", bus.o_rsp_valid); end
    total++; if (bus.o_rsp_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_rdata got=%h exp=ffff8001", bus.o_rsp_rdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_misaligned();
    present(1'b0, 32'h401, 32'h0, 2'b10, 1'b0);
    bus.i_mem_ready = 1'b1;
    step();  // T+1
    bus.i_req_valid = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    total++; if (bus.o_mem_ren !== 1'b0) begin bad++; $display("FAIL mis_ren got=%b exp=0", bus.o_mem_ren); end
    total++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_misaligned !== 1'b1) begin bad++; $display("FAIL mis_rsp valid=%b misal=%b exp 1/1", bus.o_rsp_valid, bus.o_rsp_misaligned); end
    total++; if (bus.o_rsp_rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", bus.o_rsp_rdata); end
    step();
    total++; if (bus.o_req_ready !== 1'b1) begin bad++; $display("FAIL mis_ready got=%b exp=1", bus.o_req_ready); end
`else
    total++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_addr !== 32'h400) begin bad++; $display("FAIL mis_align ren=%b addr=%h exp 1/400", bus.o_mem_ren, bus.o_mem_addr); end
    step();  // T+2
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'hCAFEF00D;
    step();  // T+3
    bus.i_mem_valid = 1'b0;
    total++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_misaligned !== 1'b0) begin bad++; $display("FAIL mis_rsp valid=%b misal=%b exp 1/0", bus.o_rsp_valid, bus.o_rsp_misaligned); end
    total++; if (bus.o_rsp_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_rdata got=%h exp=cafef00d", bus.o_rsp_rdata); end
    step();
    present(1'b1, 32'h105, 32'h00001234, 2'b01, 1'b0);
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_req_valid = 1'b0;
    total++; if (bus.o_mem_addr !== 32'h104 || bus.o_mem_mask !== 4'b0011) begin bad++; $display("FAIL mis_sh addr=%h mask=%b exp 104/0011", bus.o_mem_addr, bus.o_mem_mask); end
    total++; if (bus.o_mem_wdata !== 32'h12341234) begin bad++; $display("FAIL mis_sh_wdata got=%h exp=12341234", bus.o_mem_wdata); end
    step(); step();
`endif
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    present(1'b0, 32'h500, 32'h0, 2'b10, 1'b0);
    bus.i_mem_ready = 1'b1;
    step();  // T+1 REQ
    bus.i_req_valid = 1'b0;
    step();  // T+2 WAIT
    bus.i_mem_ready = 1'b0;
    i_rst_n = 1'b0;
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h77777777;
    step();
    i_rst_n = 1'b1;
    bus.i_mem_valid = 1'b0;
    total++; if (bus.o_rsp_valid !== 1'b0 || bus.o_mem_ren !== 1'b0) begin bad++; $display("FAIL rm_abort valid=%b ren=%b exp 0/0", bus.o_rsp_valid, bus.o_mem_ren); end
    step();
    total++; if (bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin bad++; $display("FAIL rm_idle valid=%b ready=%b exp 0/1", bus.o_rsp_valid, bus.o_req_ready); end
    present(1'b1, 32'h502, 32'h0000BEEF, 2'b01, 1'b0);
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_req_valid = 1'b0;
    total++; if (bus.o_mem_mask !== 4'b1100 || bus.o_mem_wdata !== 32'hBEEFBEEF) begin bad++; $display("FAIL rm_sh mask=%b wdata=%h exp 1100/beefbeef", bus.o_mem_mask, bus.o_mem_wdata); end
    step();
    total++; if (bus.o_rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_rsp got=%b exp=1", bus.o_rsp_valid); end
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    bus.i_mem_ready = 1'b1;
    present(1'b1, 32'h600, 32'h11111111, 2'b10, 1'b0);
    step();  // T+1: next request held by requester
    present(1'b1, 32'h701, 32'h0000003C, 2'b00, 1'b0);
    total++; if (bus.o_req_ready !== 1'b0 || bus.o_mem_addr !== 32'h600) begin bad++; $display("FAIL b2b_t1 ready=%b addr=%h exp 0/600", bus.o_req_ready, bus.o_mem_addr); end
    step();  // T+2
    total++; if (bus.o_rsp_valid !== 1'b1 || bus.o_req_ready !== 1'b0) begin bad++; $display("FAIL b2b_t2 valid=%b ready=%b exp 1/0", bus.o_rsp_valid, bus.o_req_ready); end
    step();  // T+3
    total++; if (bus.o_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_t3 ready=%b exp=1", bus.o_req_ready); end
    step();  // T+4
    bus.i_req_valid = 1'b0;
    total++; if (bus.o_mem_wen !== 1'b1 || bus.o_mem_addr !== 32'h700 || bus.o_mem_mask !== 4'b0010) begin
      bad++; $display("FAIL b2b_t4 wen=%b addr=%h mask=%b exp 1/700/0010", bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_mask);
    end
    total++; if (bus.o_mem_wdata !== 32'h3C3C3C3C) begin bad++; $display("FAIL b2b_wdata got=%h exp=3c3c3c3c", bus.o_mem_wdata); end
    step();  // T+5
    total++; if (bus.o_rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_t5 got=%b exp=1", bus.o_rsp_valid); end
    step();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte(1'b0, 32'hFFFFFF80);
    test_load_byte(1'b1, 32'h00000080);
    test_load_half_stall();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
